// File: rtl/bcd2bin_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM state encoding, digit width and the per-digit correction constants
// used by the reverse double-dabble cell.
package bcd2bin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] COR_THRESH = 4'd8;
  localparam logic [DIGIT_W-1:0] COR_VAL    = 4'd3;

  // True when a BCD digit holds a non-decimal code (10..15).
  function automatic logic digit_over9(input logic [DIGIT_W-1:0] d);
    return (d > 4'd9);
  endfunction

endpackage

// File: rtl/bcd2binary_seq_if.sv
// Valid/ready bus for the BCD-to-binary converter: BCD word in,
// binary result (plus digit error flag) out.
interface bcd2binary_seq_if
  import bcd2bin_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic [DIGIT_W*DIGITS-1:0] in;
  logic                      in_valid;
  logic                      in_ready;
  logic [BIN_W-1:0]          out;
  logic                      out_valid;
  logic                      out_ready;
  logic                      err;

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_valid, err
  );

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_valid, err
  );
endinterface

// File: rtl/bcd2binary_seq_cond_sub3.sv
// Reverse double-dabble correction cell: a digit that reached 8 or more
// after the right shift has 3 taken off. Mirror of the forward
// converter's conditional-add-3 cell.
module cond_sub3
  import bcd2bin_pkg::*;
(
  input  logic [DIGIT_W-1:0] din_i,
  output logic [DIGIT_W-1:0] dout_o
);
  assign dout_o = (din_i >= COR_THRESH) ? (din_i - COR_VAL) : din_i;
endmodule

// File: rtl/bcd2binary_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble), one bit per
// clock. Accepts a word in IDLE, spends 4*DIGITS cycles in SHIFT, then
// presents the result in DONE until the sink takes it.
// Optional build macro: BCD2BIN_DIGIT_CHECK_EN enables flagging of input
// digits above 9 on err; without it err is tied low.
module bcd2binary_seq
  import bcd2bin_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
)(
  input  logic                  clk,
  input  logic                  reset,
  bcd2binary_seq_if.slave       bus
);
  localparam int W     = DIGIT_W * DIGITS;
  localparam int NSTEP = 4 * DIGITS;
  localparam int CNT_W = $clog2(NSTEP);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTEP - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     bcd_q, bcd_d;
  logic [W-1:0]     bin_q, bin_d;
  logic [W-1:0]     bcd_sh, bin_sh, bcd_cor;

  // One right shift of the combined {bcd, bin} register per step.
  assign {bcd_sh, bin_sh} = {bcd_q, bin_q} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cor
    cond_sub3 u_cor (
      .din_i  (bcd_sh[g*DIGIT_W +: DIGIT_W]),
      .dout_o (bcd_cor[g*DIGIT_W +: DIGIT_W])
    );
  end

  // State, step counter and shift registers; reset aborts any conversion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
    end
  end

  // Next-state: load on accept, shift/correct in SHIFT, release on output handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          bcd_d   = bus.in;
          bin_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = bcd_cor;
        bin_d = bin_sh;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out       = (state_q == ST_DONE) ? BIN_W'(bin_q) : '0;

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic err_q, err_d, any_bad;

  // Any non-decimal digit in the word being offered.
  always_comb begin
    any_bad = 1'b0;
    for (int g = 0; g < DIGITS; g++) begin
      any_bad = any_bad | digit_over9(bus.in[g*DIGIT_W +: DIGIT_W]);
    end
  end

  // Error flag captured at acceptance, dropped when the result is taken.
  always_comb begin
    err_d = err_q;
    if (state_q == ST_IDLE && bus.in_valid)      err_d = any_bad;
    else if (state_q == ST_DONE && bus.out_ready) err_d = 1'b0;
  end

  // Error flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2binary_seq.sv
// Directed bench for bcd2binary_seq (DIGITS=3, BIN_W=10).
// Build with BCD2BIN_DIGIT_CHECK_EN defined to expect err on bad digits.
module tb_bcd2binary_seq;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;
  int   v;
  int   st;
  logic exp_err_bad;

  always #5 clk = ~clk;

  bcd2binary_seq_if #(.DIGITS(3), .BIN_W(10)) bus ();

  bcd2binary_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word and return just after the accepting edge.
  task automatic send(input logic [11:0] word);
    int guard;
    bus.in       = word;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("send_timeout", 32'd0, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in       = 12'h888;
  endtask

  // Count cycles until out_valid, bounded.
  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  function automatic logic [11:0] to_bcd(input int d);
    logic [3:0] h, t, o;
    h = 4'(d / 100);
    t = 4'((d / 10) % 10);
    o = 4'(d % 10);
    return {h, t, o};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
    exp_err_bad = 1'b1;
`else
    exp_err_bad = 1'b0;
`endif
    bus.in        = 12'h000;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    tick();
    tick();
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out",       32'(bus.out),       32'd0);
    check("rst_err",       32'(bus.err),       32'd0);
    reset = 1'b0;
    tick();

    // 123 with latency and in_ready checks
    send(12'h123);
    check("t1_busy_in_ready", 32'(bus.in_ready), 32'd0);
    wait_out(lat);
    check("t1_latency", 32'(lat),           32'd12);
    check("t1_out",     32'(bus.out),       32'd123);
    check("t1_err",     32'(bus.err),       32'd0);
    check("t1_inrdy",   32'(bus.in_ready),  32'd0);
    tick();
    check("t1_pulse",   32'(bus.out_valid), 32'd0);
    check("t1_rdy_back", 32'(bus.in_ready), 32'd1);

    // back-to-back 999, 000, 255
    send(12'h999); wait_out(lat);
    check("t2a_latency", 32'(lat), 32'd12);
    check("t2a_out", 32'(bus.out), 32'd999);
    tick();
    check("t2a_pulse", 32'(bus.out_valid), 32'd0);
    send(12'h000); wait_out(lat);
    check("t2b_latency", 32'(lat), 32'd12);
    check("t2b_out", 32'(bus.out), 32'd0);
    tick();
    send(12'h255); wait_out(lat);
    check("t2c_latency", 32'(lat), 32'd12);
    check("t2c_out", 32'(bus.out), 32'd255);
    tick();

    // 045 with five stalled cycles in DONE
    bus.out_ready = 1'b0;
    send(12'h045); wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_out",   32'(bus.out),       32'd45);
      check("t3_stall_valid", 32'(bus.out_valid), 32'd1);
      check("t3_stall_inrdy", 32'(bus.in_ready),  32'd0);
      tick();
    end
    check("t3_still_out", 32'(bus.out), 32'd45);
    bus.out_ready = 1'b1;
    tick();
    check("t3_released", 32'(bus.out_valid), 32'd0);

    // reset during step 6 of 777, then 050
    send(12'h777);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("t4_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t4_rst_out",   32'(bus.out),       32'd0);
    check("t4_rst_inrdy", 32'(bus.in_ready),  32'd1);
    tick();
    reset = 1'b0;
    tick();
    send(12'h050); wait_out(lat);
    check("t4_latency", 32'(lat), 32'd12);
    check("t4_out", 32'(bus.out), 32'd50);
    tick();

    // invalid digit, then a clean word
    send(12'h1A3); wait_out(lat);
    check("t5_bad_valid", 32'(bus.out_valid), 32'd1);
    check("t5_bad_err",   32'(bus.err),       32'(exp_err_bad));
    tick();
    check("t5_err_clear", 32'(bus.err), 32'd0);
    send(12'h100); wait_out(lat);
    check("t5_out", 32'(bus.out), 32'd100);
    check("t5_err", 32'(bus.err), 32'd0);
    tick();

    // random sweep with idle gaps and output stalls
    for (int i = 0; i < 30; i++) begin
      v = (i == 0) ? 0 : (i == 1) ? 999 : int'($urandom_range(0, 999));
      repeat ($urandom_range(0, 3)) tick();
      send(to_bcd(v));
      wait_out(lat);
      check("sw_valid", 32'(bus.out_valid), 32'd1);
      check("sw_out",   32'(bus.out),       32'(v));
      st = int'($urandom_range(0, 3));
      bus.out_ready = 1'b0;
      for (int k = 0; k < st; k++) begin
        tick();
        check("sw_stall_out", 32'(bus.out), 32'(v));
      end
      bus.out_ready = 1'b1;
      tick();
      check("sw_no_dup", 32'(bus.out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
